bmp_read_ctrl: RTL and testbench
================================

BMP_READ_CTRL -- requirements
Module: bmp_read_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 20: byte-address width of the image memory.
REQ-002 SHALL have parameter DIM_W, default 16: width of the width, height and coordinate fields.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle pulse that begins a parse-and-stream pass.
REQ-006 SHALL have port mem_rd, output, 1: byte read strobe.
REQ-007 SHALL have port mem_addr, output, ADDR_W: byte address.
REQ-008 SHALL have port mem_rdata, input, 8: read byte, valid exactly one cycle after mem_rd.
REQ-009 SHALL have port pix_valid, output, 1: pixel available.
REQ-010 SHALL have port pix_ready, input, 1: consumer accepts the pixel.
REQ-011 SHALL have port pix_data, output, 24: pixel as {R,G,B}.
REQ-012 SHALL have ports pix_x and pix_y, output, DIM_W each: pixel coordinates.
REQ-013 SHALL have ports img_width and img_height, output, DIM_W each: parsed dimensions.
REQ-014 SHALL have ports busy, done and err, output, 1 each: status flags.

Function
REQ-015 States SHALL be IDLE, HDR, CHECK, FETCH, PRESENT, PAD, DONE, ERR.
REQ-016 IDLE SHALL move to HDR on start; start outside IDLE, DONE or ERR SHALL be ignored.
REQ-017 DONE or ERR SHALL move to HDR on start and clear done/err in that cycle.
REQ-018 HDR SHALL read addresses 0..29 sequentially and capture fields little-endian.
REQ-019 Captured fields: signature bytes 0-1, data offset bytes 10-13, width bytes 18-21, height bytes 22-25, bpp bytes 28-29.
REQ-020 CHECK SHALL go to ERR if the signature is not 0x42,0x4D.
REQ-021 CHECK SHALL go to ERR if bpp is not 24.
REQ-022 CHECK SHALL go to ERR if width or height is 0 or does not fit in DIM_W bits; otherwise it goes to FETCH.
REQ-023 Row stride SHALL be 3*width rounded up to a multiple of 4.
REQ-024 Padding SHALL be (4 - (3*width mod 4)) mod 4 bytes.
REQ-025 The first pixel byte SHALL be at the data offset; the file is bottom-up.
REQ-026 FETCH SHALL read 3 consecutive bytes (B, G, R) into a holding register, then go to PRESENT.
REQ-027 PRESENT SHALL assert pix_valid with pix_data, pix_x and pix_y held stable until the cycle pix_valid && pix_ready.
REQ-028 No memory read SHALL be issued while in PRESENT.
REQ-029 pix_x SHALL run 0..width-1 within a row; pix_y SHALL start at height-1 and decrement per row.
REQ-030 On acceptance of the last pixel of a row, the block SHALL go to PAD if padding > 0, else to FETCH.
REQ-031 PAD SHALL advance the address pointer by the padding bytes in one cycle, without memory reads.
REQ-032 Acceptance of pixel (width-1, 0) SHALL go to DONE; done SHALL stay high until the next start or rst.
REQ-033 ERR SHALL hold err high until the next start or rst and SHALL emit no pixels.
REQ-034 busy SHALL be high in HDR, CHECK, FETCH, PRESENT and PAD.
REQ-035 img_width and img_height SHALL be valid from the cycle after CHECK until the next start.
REQ-036 mem_addr SHALL be computed with ADDR_W-bit wrap-around; the address pointer SHALL be a running pointer (no multiplier).

Reset
REQ-037 rst SHALL force IDLE in any state, including mid-stream, with the pixel in flight discarded.
REQ-038 All outputs SHALL reset to 0: mem_rd, mem_addr, pix_valid, pix_data, pix_x, pix_y, img_width, img_height, busy, done, err.
REQ-039 rst SHALL take priority over start in the same cycle.

Structure
REQ-040 Package bmp_pkg SHALL hold the header byte offsets, the signature constant, BPP_24 and the state enumeration.
REQ-041 Header capture SHALL be sub-module bmp_hdr_parser (byte index plus data in, registered fields out).

Verification
REQ-042 2x2 image, offset 54, ready always high -> 4 pixels at (0,1),(1,1),(0,0),(1,0); addresses 54-59, 62-67; padding 2; done.
REQ-043 4x1 image (stride 12, no padding) -> addresses 54-65 contiguous, PAD never entered, pix_y=0 throughout.
REQ-044 Byte 0 = 0x42, byte 1 = 0x4E -> err=1, pix_valid never high, busy low after ERR.
REQ-045 bpp=8 -> err=1; a following start with a corrected image -> err cleared, normal stream.
REQ-046 pix_ready low for 5 cycles on pixel 1 -> pix_data/x/y stable, mem_rd=0 throughout, stream resumes unchanged.
REQ-047 rst pulsed during PRESENT of pixel 2 -> next cycle state IDLE, all outputs 0; new start reparses from address 0.

Source files
------------

// File: rtl/bmp_read_ctrl_pkg.sv
// Shared constants and state encoding for the BMP read controller.
// Header byte offsets, the "BM" signature and the 24-bit colour depth code.
package bmp_pkg;

    localparam logic [4:0]  HDR_BYTES  = 5'd30;
    localparam logic [4:0]  OFF_SIG    = 5'd0;
    localparam logic [4:0]  OFF_DOFF   = 5'd10;
    localparam logic [4:0]  OFF_WIDTH  = 5'd18;
    localparam logic [4:0]  OFF_HEIGHT = 5'd22;
    localparam logic [4:0]  OFF_BPP    = 5'd28;

    localparam logic [15:0] SIGNATURE  = 16'h4D42;  // 'B' at byte 0, 'M' at byte 1
    localparam logic [15:0] BPP_24     = 16'd24;

    typedef enum logic [2:0] {
        IDLE, HDR, CHECK, FETCH, PRESENT, PAD, DONE, ERR
    } state_t;

endpackage

// File: rtl/bmp_read_ctrl_if.sv
// Memory read port and pixel stream of the BMP read controller, bundled.
// master = controller side, slave = memory/consumer side.
interface bmp_read_ctrl_if #(
    parameter int ADDR_W = 20,
    parameter int DIM_W  = 16
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              pix_valid;
    logic              pix_ready;
    logic [23:0]       pix_data;
    logic [DIM_W-1:0]  pix_x;
    logic [DIM_W-1:0]  pix_y;

    modport master (
        output mem_rd, mem_addr, pix_valid, pix_data, pix_x, pix_y,
        input  mem_rdata, pix_ready
    );

    modport slave (
        input  mem_rd, mem_addr, pix_valid, pix_data, pix_x, pix_y,
        output mem_rdata, pix_ready
    );
endinterface

// File: rtl/bmp_read_ctrl_hdr.sv
// Header field capture: takes (byte index, byte) pairs of the first 30 file
// bytes and assembles the little-endian fields into registers.
module bmp_hdr_parser
    import bmp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_vld_i,
    input  logic [4:0]  byte_idx_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] sig_o,
    output logic [31:0] doff_o,
    output logic [31:0] width_o,
    output logic [31:0] height_o,
    output logic [15:0] bpp_o
);
    logic [15:0] sig_q, bpp_q;
    logic [31:0] doff_q, width_q, height_q;
    logic [4:0]  rel_sig, rel_doff, rel_w, rel_h, rel_bpp;

    // Offset relative to each field base; upper bits zero means "inside".
    assign rel_sig  = byte_idx_i - OFF_SIG;
    assign rel_doff = byte_idx_i - OFF_DOFF;
    assign rel_w    = byte_idx_i - OFF_WIDTH;
    assign rel_h    = byte_idx_i - OFF_HEIGHT;
    assign rel_bpp  = byte_idx_i - OFF_BPP;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q    <= '0;
            doff_q   <= '0;
            width_q  <= '0;
            height_q <= '0;
            bpp_q    <= '0;
        end else if (byte_vld_i) begin
            if (rel_sig[4:1] == 4'd0)  sig_q[{rel_sig[0], 3'b000} +: 8]       <= byte_i;
            if (rel_doff[4:2] == 3'd0) doff_q[{rel_doff[1:0], 3'b000} +: 8]  <= byte_i;
            if (rel_w[4:2] == 3'd0)    width_q[{rel_w[1:0], 3'b000} +: 8]    <= byte_i;
            if (rel_h[4:2] == 3'd0)    height_q[{rel_h[1:0], 3'b000} +: 8]   <= byte_i;
            if (rel_bpp[4:1] == 4'd0)  bpp_q[{rel_bpp[0], 3'b000} +: 8]      <= byte_i;
        end
    end

    assign sig_o    = sig_q;
    assign doff_o   = doff_q;
    assign width_o  = width_q;
    assign height_o = height_q;
    assign bpp_o    = bpp_q;
endmodule

// File: rtl/bmp_read_ctrl.sv
// 24-bit BMP reader: parses the header, validates it, then streams pixels
// bottom-up with a valid/ready handshake, skipping row padding.
module bmp_read_ctrl
    import bmp_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int DIM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [23:0]       pix_data,
    output logic [DIM_W-1:0]  pix_x,
    output logic [DIM_W-1:0]  pix_y,
    output logic [DIM_W-1:0]  img_width,
    output logic [DIM_W-1:0]  img_height,
    output logic              busy,
    output logic              done,
    output logic              err
);
    state_t            state_q, state_d;
    logic [4:0]        cnt_q, idx_q;
    logic              rd_vld_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [1:0]        pad_q;
    logic [23:0]       pix_q;
    logic [DIM_W-1:0]  x_q, y_q, w_q, h_q;

    logic [15:0] hdr_sig, hdr_bpp;
    logic [31:0] hdr_doff, hdr_width, hdr_height;
    logic        hdr_ok, row_end;

    bmp_hdr_parser u_hdr (
        .clk        (clk),
        .rst        (rst),
        .byte_vld_i (rd_vld_q && state_q == HDR),
        .byte_idx_i (idx_q),
        .byte_i     (mem_rdata),
        .sig_o      (hdr_sig),
        .doff_o     (hdr_doff),
        .width_o    (hdr_width),
        .height_o   (hdr_height),
        .bpp_o      (hdr_bpp)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        hdr_ok = (hdr_sig == SIGNATURE) && (hdr_bpp == BPP_24) &&
                 (hdr_width != 32'd0) && (hdr_height != 32'd0) &&
                 ((hdr_width >> DIM_W) == 32'd0) && ((hdr_height >> DIM_W) == 32'd0);
        row_end   = (x_q == w_q - DIM_W'(1));
        state_d   = state_q;
        mem_rd    = 1'b0;
        pix_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            IDLE:    if (start) state_d = HDR;
            HDR: begin
                busy   = 1'b1;
                mem_rd = (cnt_q < HDR_BYTES);
                if (rd_vld_q && idx_q == HDR_BYTES - 5'd1) state_d = CHECK;
            end
            CHECK: begin
                busy    = 1'b1;
                state_d = hdr_ok ? FETCH : ERR;
            end
            FETCH: begin
                busy   = 1'b1;
                mem_rd = (cnt_q < 5'd3);
                if (rd_vld_q && idx_q == 5'd2) state_d = PRESENT;
            end
            PRESENT: begin
                busy      = 1'b1;
                pix_valid = 1'b1;
                if (pix_ready) begin
                    if (!row_end)             state_d = FETCH;
                    else if (y_q == '0)       state_d = DONE;
                    else if (pad_q != 2'd0)   state_d = PAD;
                    else                      state_d = FETCH;
                end
            end
            PAD: begin
                busy    = 1'b1;
                state_d = FETCH;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_d = HDR;
            end
            ERR: begin
                err = 1'b1;
                if (start) state_d = HDR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            rd_vld_q <= 1'b0;
            ptr_q    <= '0;
            pad_q    <= '0;
            pix_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
        end else begin
            // Read data returns one cycle later; remember which byte it is.
            rd_vld_q <= mem_rd;
            idx_q    <= cnt_q;
            if (mem_rd) begin
                cnt_q <= cnt_q + 5'd1;
                ptr_q <= ptr_q + ADDR_W'(1);
            end
            case (state_q)
                IDLE, DONE, ERR: if (start) begin
                    cnt_q <= '0;
                    ptr_q <= '0;
                    w_q   <= '0;
                    h_q   <= '0;
                end
                CHECK: begin
                    cnt_q <= '0;
                    ptr_q <= ADDR_W'(hdr_doff);
                    // (4 - 3w mod 4) mod 4 reduces to w mod 4.
                    pad_q <= hdr_width[1:0];
                    x_q   <= '0;
                    y_q   <= DIM_W'(hdr_height) - DIM_W'(1);
                    if (hdr_ok) begin
                        w_q <= DIM_W'(hdr_width);
                        h_q <= DIM_W'(hdr_height);
                    end
                end
                FETCH: if (rd_vld_q) pix_q[{idx_q[1:0], 3'b000} +: 8] <= mem_rdata;
                PRESENT: if (pix_ready) begin
                    cnt_q <= '0;
                    if (!row_end) begin
                        x_q <= x_q + DIM_W'(1);
                    end else if (y_q != '0) begin
                        x_q <= '0;
                        y_q <= y_q - DIM_W'(1);
                    end
                end
                PAD: ptr_q <= ptr_q + ADDR_W'(pad_q);
                default: ;
            endcase
        end
    end

    assign mem_addr   = ptr_q;
    assign pix_data   = pix_q;
    assign pix_x      = x_q;
    assign pix_y      = y_q;
    assign img_width  = w_q;
    assign img_height = h_q;
endmodule

// File: tb/tb_bmp_read_ctrl.sv
// Self-checking bench for bmp_read_ctrl: random images in a byte memory,
// expected address/pixel sequences derived from BMP layout arithmetic.
module tb_bmp_read_ctrl;
    localparam int ADDR_W = 20;
    localparam int DIM_W  = 16;

    logic clk = 1'b0;
    logic rst, start;
    logic [DIM_W-1:0] img_width, img_height;
    logic busy, done, err;

    bmp_read_ctrl_if #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus ();

    bmp_read_ctrl #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mem_rd     (bus.mem_rd),
        .mem_addr   (bus.mem_addr),
        .mem_rdata  (bus.mem_rdata),
        .pix_valid  (bus.pix_valid),
        .pix_ready  (bus.pix_ready),
        .pix_data   (bus.pix_data),
        .pix_x      (bus.pix_x),
        .pix_y      (bus.pix_y),
        .img_width  (img_width),
        .img_height (img_height),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:1023];
    always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr[9:0]];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observed and expected streams.
    int          addr_obs[$], addr_exp[$];
    logic [55:0] pix_obs[$],  pix_exp[$];
    int acc_cnt, rd_viol, stab_viol, stall_n, ready_mode;
    logic        pend;
    logic [55:0] pend_v;

    initial begin
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.mem_rd) addr_obs.push_back(int'(bus.mem_addr));
                if (bus.mem_rd && bus.pix_valid) rd_viol++;
                if (pend && bus.pix_valid && {bus.pix_x, bus.pix_y, bus.pix_data} != pend_v) stab_viol++;
                if (bus.pix_valid && bus.pix_ready) begin
                    pix_obs.push_back({bus.pix_x, bus.pix_y, bus.pix_data});
                    acc_cnt++;
                end
                pend   = bus.pix_valid && !bus.pix_ready;
                pend_v = {bus.pix_x, bus.pix_y, bus.pix_data};
            end else begin
                pend = 1'b0;
            end
        end
    end

    // Consumer ready: 0 always, 1 random, 2 stall pixel 1 five cycles, 3 block from pixel 2.
    initial begin
        bus.pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: bus.pix_ready = ($urandom_range(0, 3) != 0);
                2: if (bus.pix_valid && acc_cnt == 1 && stall_n < 5) begin
                       bus.pix_ready = 1'b0;
                       stall_n++;
                   end else bus.pix_ready = 1'b1;
                3: bus.pix_ready = (acc_cnt < 2);
                default: bus.pix_ready = 1'b1;
            endcase
        end
    end

    task automatic put_le(input int a, input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) mem[a + i] = v[8*i +: 8];
    endtask

    task automatic make_img(input logic [31:0] w, input logic [31:0] h, input int off,
                            input logic [7:0] sig1, input logic [15:0] bpp);
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h42;
        mem[1] = sig1;
        put_le(10, 4, off);
        put_le(18, 4, w);
        put_le(22, 4, h);
        put_le(28, 2, {16'd0, bpp});
    endtask

    // Reference: header bytes 0..29, then bottom-up rows at offset + r*stride.
    task automatic build_expect(input int w, input int h, input int off, input bit pixels);
        int stride, a;
        addr_exp.delete();
        pix_exp.delete();
        for (int i = 0; i < 30; i++) addr_exp.push_back(i);
        if (pixels) begin
            stride = ((3 * w + 3) / 4) * 4;
            for (int r = 0; r < h; r++)
                for (int x = 0; x < w; x++) begin
                    a = off + r * stride + 3 * x;
                    for (int k = 0; k < 3; k++) addr_exp.push_back(a + k);
                    pix_exp.push_back({16'(x), 16'(h - 1 - r), mem[a + 2], mem[a + 1], mem[a]});
                end
        end
    endtask

    task automatic pulse_start();
        addr_obs.delete();
        pix_obs.delete();
        acc_cnt = 0; rd_viol = 0; stab_viol = 0; stall_n = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_pass(input string tag, input int w, input int h, input int off,
                            input bit exp_err);
        bit timeout;
        build_expect(w, h, off, !exp_err);
        pulse_start();
        @(negedge clk);
        check({tag, ".busy_after_start"}, {busy, done, err}, 3'b100);
        timeout = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (done || err) begin timeout = 1'b0; break; end
            @(negedge clk);
        end
        check({tag, ".timeout"}, timeout, 1'b0);
        check({tag, ".flags"}, {busy, done, err}, {1'b0, !exp_err, exp_err});
        check({tag, ".n_addr"}, addr_obs.size(), addr_exp.size());
        for (int i = 0; i < addr_obs.size() && i < addr_exp.size(); i++)
            check($sformatf("%s.addr[%0d]", tag, i), addr_obs[i], addr_exp[i]);
        check({tag, ".n_pix"}, pix_obs.size(), pix_exp.size());
        for (int i = 0; i < pix_obs.size() && i < pix_exp.size(); i++)
            check($sformatf("%s.pix[%0d]", tag, i), pix_obs[i], pix_exp[i]);
        check({tag, ".rd_in_present"}, rd_viol, 0);
        check({tag, ".stable"}, stab_viol, 0);
        if (!exp_err) check({tag, ".dims"}, {img_width, img_height}, {16'(w), 16'(h)});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit timeout;
        ready_mode = 0;
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset.outs", {bus.mem_rd, bus.mem_addr, bus.pix_valid, bus.pix_data},
              {1'b0, 20'd0, 1'b0, 24'd0});
        check("reset.coords", {bus.pix_x, bus.pix_y, img_width, img_height}, 64'd0);
        check("reset.flags", {busy, done, err}, 3'b000);

        make_img(2, 2, 54, 8'h4D, 16'd24);
        run_pass("img2x2", 2, 2, 54, 1'b0);

        make_img(4, 1, 54, 8'h4D, 16'd24);
        run_pass("img4x1", 4, 1, 54, 1'b0);

        make_img(2, 2, 54, 8'h4E, 16'd24);
        run_pass("badsig", 2, 2, 54, 1'b1);

        make_img(3, 2, 60, 8'h4D, 16'd8);
        run_pass("bpp8", 3, 2, 60, 1'b1);
        put_le(28, 2, 32'd24);
        run_pass("bpp_fixed", 3, 2, 60, 1'b0);

        make_img(0, 2, 54, 8'h4D, 16'd24);
        run_pass("width0", 0, 2, 54, 1'b1);
        make_img(32'h0001_0000, 1, 54, 8'h4D, 16'd24);
        run_pass("width_big", 1, 1, 54, 1'b1);
        make_img(1, 0, 54, 8'h4D, 16'd24);
        run_pass("height0", 1, 0, 54, 1'b1);

        ready_mode = 2;
        make_img(3, 2, 54, 8'h4D, 16'd24);
        run_pass("stall", 3, 2, 54, 1'b0);
        check("stall.cycles", stall_n, 5);

        // Reset while pixel 2 is being presented.
        ready_mode = 3;
        make_img(3, 2, 70, 8'h4D, 16'd24);
        pulse_start();
        timeout = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (acc_cnt == 2 && bus.pix_valid) begin timeout = 1'b0; break; end
        end
        check("rst_mid.reach_pix2", timeout, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid.outs", {bus.mem_rd, bus.mem_addr, bus.pix_valid, bus.pix_data},
              {1'b0, 20'd0, 1'b0, 24'd0});
        check("rst_mid.coords", {bus.pix_x, bus.pix_y, img_width, img_height}, 64'd0);
        check("rst_mid.flags", {busy, done, err}, 3'b000);
        rst = 1'b0;
        ready_mode = 0;
        run_pass("rst_restart", 3, 2, 70, 1'b0);

        ready_mode = 1;
        for (int t = 0; t < 6; t++) begin
            int w, h, off;
            w   = $urandom_range(1, 7);
            h   = $urandom_range(1, 4);
            off = $urandom_range(54, 150);
            make_img(w, h, off, 8'h4D, 16'd24);
            run_pass($sformatf("rand%0d", t), w, h, off, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
